// File: rtl/dp_pkg.sv
// dp_pkg: mode and state encodings shared by the dp_pipe datapath.
package dp_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_ADD = 2'b00;
    localparam mode_t MODE_SUB = 2'b01;
    localparam mode_t MODE_ACC = 2'b10;
    localparam mode_t MODE_CLR = 2'b11;
    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
endpackage

// File: rtl/dp_arith.sv
// dp_arith: combinational add/sub/clear with optional saturation.
module dp_arith import dp_pkg::*; #(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_t            mode,
    output logic [WIDTH-1:0] result,
    output logic             carry
);
    logic [WIDTH:0] w_sum;
    always_comb begin
        w_sum  = mode == MODE_SUB ? {1'b0, a} - {1'b0, b} :
                 mode == MODE_CLR ? '0 : {1'b0, a} + {1'b0, b};
        carry  = w_sum[WIDTH];
        result = (SAT && carry) ? (mode == MODE_SUB ? '0 : '1) : w_sum[WIDTH-1:0];
    end
endmodule

// File: rtl/dp_pipe.sv
// dp_pipe: three-state arithmetic pipeline with accumulator and start/busy/done handshake.
module dp_pipe import dp_pkg::*; #(
    parameter int WIDTH = 4,
    parameter bit SAT   = 1'b0
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d1_in,
    input  logic [WIDTH-1:0] d2_in,
    output logic [WIDTH-1:0] d_out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);
    state_t           r_state, w_next;
    mode_t            r_mode;
    logic [WIDTH-1:0] r_temp_1, r_temp_2, r_temp_result, r_acc;
    logic             r_carry;
    logic [WIDTH-1:0] w_a, w_b, w_res;
    logic             w_carry;
    always_comb begin
        w_next = r_state == IDLE ? (start ? CALC : IDLE) : r_state == CALC ? OUT : IDLE;
        w_a    = r_mode == MODE_ACC ? r_acc : r_temp_1;
        w_b    = r_mode == MODE_ACC ? r_temp_1 : r_temp_2;
    end
    dp_arith #(.WIDTH(WIDTH), .SAT(SAT)) u_arith (
        .a(w_a), .b(w_b), .mode(r_mode), .result(w_res), .carry(w_carry)
    );
    always_ff @(posedge clka) begin
        if (restart) begin
            r_state       <= IDLE;
            r_mode        <= MODE_ADD;
            r_temp_1      <= '0;
            r_temp_2      <= '0;
            r_temp_result <= '0;
            r_carry       <= 1'b0;
            r_acc         <= '0;
            d_out         <= '0;
            carry_out     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= r_state == OUT;
            busy    <= r_state == IDLE ? start : 1'b1;
            if (r_state == IDLE && start) begin
                r_temp_1 <= d1_in;
                r_temp_2 <= d2_in;
                r_mode   <= mode;
            end
            if (r_state == CALC) begin
                r_temp_result <= w_res;
                r_carry       <= w_carry;
            end
            if (r_state == OUT) begin
                d_out     <= r_temp_result;
                carry_out <= r_carry;
                if (r_mode == MODE_ACC || r_mode == MODE_CLR) r_acc <= r_temp_result;
            end
        end
    end
endmodule
